// File: rtl/condiciona_botoes.sv
// Button conditioning: 2-flop synchroniser, whole-vector debounce and a
// press/release FSM that emits one strobe per accepted single-button press.
module condiciona_botoes #(
   parameter int N_BOTOES        = 7,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [N_BOTOES-1:0] botoes,
   input  logic                habilita,
   output logic [N_BOTOES-1:0] jogada,
   output logic                jogada_pulso,
   output logic                multiplo,
   output logic [N_BOTOES-1:0] estavel,
   output logic [2:0]          db_estado
);

   typedef enum logic [2:0] {
      SOLTO         = 3'd0,
      PRESSIONADO   = 3'd1,
      ESPERA_SOLTAR = 3'd2
   } estado_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [N_BOTOES-1:0] s1_reg, s2_reg, cand_reg, estavel_reg;
   logic [CNT_W-1:0]    cnt_reg;

   estado_t             state_reg, state_next;
   logic [N_BOTOES-1:0] jogada_reg, jogada_next;
   logic                pulso_reg, pulso_next;
   logic                multiplo_reg, multiplo_next;

   logic est_zero, est_multi;

   // Synchroniser and debounce: any change of the synchronised vector restarts the count.
   always_ff @(posedge clock) begin
      if (reset) begin
         s1_reg      <= '0;
         s2_reg      <= '0;
         cand_reg    <= '0;
         cnt_reg     <= '0;
         estavel_reg <= '0;
      end else begin
         s1_reg <= botoes;
         s2_reg <= s1_reg;
         if (s2_reg != cand_reg) begin
            cand_reg <= s2_reg;
            cnt_reg  <= '0;
         end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end else begin
            estavel_reg <= cand_reg;
         end
      end
   end

   assign est_zero  = (estavel_reg == '0);
   assign est_multi = |(estavel_reg & (estavel_reg - N_BOTOES'(1)));

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg    <= SOLTO;
         jogada_reg   <= '0;
         pulso_reg    <= 1'b0;
         multiplo_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         jogada_reg   <= jogada_next;
         pulso_reg    <= pulso_next;
         multiplo_reg <= multiplo_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      jogada_next   = jogada_reg;
      pulso_next    = 1'b0;
      multiplo_next = multiplo_reg;
      case (state_reg)
         SOLTO: begin
            if (!est_zero) begin
               if (est_multi) begin
                  multiplo_next = 1'b1;
                  state_next    = ESPERA_SOLTAR;
               end else if (habilita) begin
                  jogada_next = estavel_reg;
                  pulso_next  = 1'b1;
                  state_next  = PRESSIONADO;
               end else begin
                  // Press seen while disabled is swallowed until full release
                  state_next = ESPERA_SOLTAR;
               end
            end
         end
         PRESSIONADO: begin
            if (est_zero) begin
               state_next = SOLTO;
            end else if (estavel_reg != jogada_reg) begin
               multiplo_next = 1'b1;
               state_next    = ESPERA_SOLTAR;
            end
         end
         ESPERA_SOLTAR: begin
            if (est_zero) begin
               multiplo_next = 1'b0;
               state_next    = SOLTO;
            end
         end
         default: begin
            multiplo_next = 1'b0;
            state_next    = SOLTO;
         end
      endcase
   end

   assign jogada       = jogada_reg;
   assign jogada_pulso = pulso_reg;
   assign multiplo     = multiplo_reg;
   assign estavel      = estavel_reg;
   assign db_estado    = state_reg;

endmodule

// File: tb/tb_condiciona_botoes.sv
// Bench for condiciona_botoes: directed test-plan steps plus random button
// segments, every edge compared against a sample-history reference model.
module tb_condiciona_botoes;

   localparam int D = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] botoes = '0;
   logic       habilita = 1'b1;
   logic [6:0] jogada, estavel;
   logic       jogada_pulso, multiplo;
   logic [2:0] db_estado;

   int tests = 0;
   int fails = 0;
   int pulse_cnt = 0;

   // Reference model state
   logic [6:0] hist[$];
   logic [6:0] m_est, m_jog;
   logic       m_pulse, m_mult;
   int         m_state;

   condiciona_botoes #(.N_BOTOES(7), .DEBOUNCE_CYCLES(D)) dut (
      .clock(clock), .reset(reset), .botoes(botoes), .habilita(habilita),
      .jogada(jogada), .jogada_pulso(jogada_pulso), .multiplo(multiplo),
      .estavel(estavel), .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      hist.delete();
      repeat (D + 3) hist.push_back(7'd0);
      m_est = '0; m_jog = '0; m_pulse = 1'b0; m_mult = 1'b0; m_state = 0;
   endtask

   // Applies one rising edge to the model using the inputs present at that edge.
   task automatic model_edge();
      int  last;
      bit  same;
      if (reset) begin
         model_clear();
         return;
      end
      m_pulse = 1'b0;
      case (m_state)
         0: if (m_est != 0) begin
               if ($countones(m_est) > 1) begin m_mult = 1'b1; m_state = 2; end
               else if (habilita) begin m_jog = m_est; m_pulse = 1'b1; m_state = 1; end
               else m_state = 2;
            end
         1: if (m_est == 0) m_state = 0;
            else if (m_est != m_jog) begin m_mult = 1'b1; m_state = 2; end
         default: if (m_est == 0) begin m_mult = 1'b0; m_state = 0; end
      endcase
      // estavel takes a value once D+1 consecutive synchronised samples agree
      hist.push_back(botoes);
      last = hist.size() - 1;
      same = 1'b1;
      for (int i = last - 2 - D; i <= last - 2; i++)
         if (hist[i] != hist[last - 2]) same = 1'b0;
      if (same) m_est = hist[last - 2];
      if (hist.size() > 4 * D + 8) void'(hist.pop_front());
   endtask

   task automatic tick();
      @(posedge clock);
      model_edge();
      #1;
      if (jogada_pulso === 1'b1) pulse_cnt++;
      chk("estavel", 32'(estavel), 32'(m_est));
      chk("jogada", 32'(jogada), 32'(m_jog));
      chk("jogada_pulso", 32'(jogada_pulso), 32'(m_pulse));
      chk("multiplo", 32'(multiplo), 32'(m_mult));
      chk("db_estado", 32'(db_estado), 32'(m_state));
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int p0;
      logic [6:0] pat;
      int kind, len;

      model_clear();
      reset = 1'b1;
      ticks(2);
      chk("reset_jogada", 32'(jogada), 32'd0);
      chk("reset_estado", 32'(db_estado), 32'd0);
      reset = 1'b0;
      $display("[TB] reset done");

      // Clean press: pulse exactly at edge D+4
      botoes = 7'b0000100; habilita = 1'b1;
      p0 = pulse_cnt;
      ticks(D + 3);
      chk("clean_no_early_pulse", 32'(pulse_cnt - p0), 32'd0);
      tick();
      chk("clean_pulse", 32'(jogada_pulso), 32'd1);
      chk("clean_jogada", 32'(jogada), 32'h04);
      chk("clean_estado", 32'(db_estado), 32'd1);
      ticks(3);
      chk("clean_held_no_repeat", 32'(pulse_cnt - p0), 32'd1);
      // Release reaches SOLTO one edge after estavel clears
      botoes = 7'b0;
      ticks(D + 4);
      chk("release_estado", 32'(db_estado), 32'd0);
      chk("release_jogada_kept", 32'(jogada), 32'h04);
      $display("[TB] clean press/release");

      // Bounce: 2-cycle toggling never reaches estavel
      p0 = pulse_cnt;
      for (int i = 0; i < 12; i++) begin
         botoes = ((i / 2) % 2 == 0) ? 7'b0000001 : 7'b0;
         tick();
      end
      chk("bounce_no_pulse", 32'(pulse_cnt - p0), 32'd0);
      botoes = 7'b0000001;
      ticks(D + 4);
      chk("bounce_pulse", 32'(jogada_pulso), 32'd1);
      chk("bounce_jogada", 32'(jogada), 32'h01);
      botoes = 7'b0; ticks(D + 6);
      $display("[TB] bounce");

      // Multi-press
      p0 = pulse_cnt;
      botoes = 7'b0010010;
      ticks(D + 4);
      chk("multi_flag", 32'(multiplo), 32'd1);
      chk("multi_estado", 32'(db_estado), 32'd2);
      botoes = 7'b0;
      ticks(D + 4);
      chk("multi_clear", 32'(multiplo), 32'd0);
      chk("multi_estado_solto", 32'(db_estado), 32'd0);
      chk("multi_jogada_kept", 32'(jogada), 32'h01);
      chk("multi_no_pulse", 32'(pulse_cnt - p0), 32'd0);
      $display("[TB] multi-press");

      // Added button while held
      botoes = 7'b1000000; ticks(D + 4);
      chk("added_first_pulse", 32'(jogada_pulso), 32'd1);
      p0 = pulse_cnt;
      botoes = 7'b1000001; ticks(D + 4);
      chk("added_estavel", 32'(estavel), 32'h41);
      chk("added_multiplo", 32'(multiplo), 32'd1);
      chk("added_jogada_kept", 32'(jogada), 32'h40);
      chk("added_no_pulse", 32'(pulse_cnt - p0), 32'd0);
      botoes = 7'b0; ticks(D + 4);
      chk("added_solto", 32'(db_estado), 32'd0);
      botoes = 7'b0000001; ticks(D + 4);
      chk("added_repress_pulse", 32'(jogada_pulso), 32'd1);
      chk("added_repress_jogada", 32'(jogada), 32'h01);
      botoes = 7'b0; ticks(D + 6);
      $display("[TB] added button");

      // Disabled press, enable while held, then release and re-press
      p0 = pulse_cnt;
      habilita = 1'b0; botoes = 7'b0001000; ticks(D + 4);
      chk("dis_estado", 32'(db_estado), 32'd2);
      chk("dis_multiplo", 32'(multiplo), 32'd0);
      habilita = 1'b1; ticks(D + 6);
      chk("dis_no_pulse", 32'(pulse_cnt - p0), 32'd0);
      botoes = 7'b0; ticks(D + 4);
      botoes = 7'b0001000; ticks(D + 4);
      chk("dis_repress_pulse", 32'(jogada_pulso), 32'd1);
      chk("dis_repress_jogada", 32'(jogada), 32'h08);
      botoes = 7'b0; ticks(D + 6);
      $display("[TB] disabled press");

      // Reset mid-debounce with the button held through it
      botoes = 7'b0100000; ticks(4);
      reset = 1'b1; tick();
      chk("rst_mid_jogada", 32'(jogada), 32'd0);
      chk("rst_mid_estavel", 32'(estavel), 32'd0);
      chk("rst_mid_estado", 32'(db_estado), 32'd0);
      reset = 1'b0;
      ticks(D + 3);
      chk("rst_mid_no_early", 32'(jogada_pulso), 32'd0);
      tick();
      chk("rst_mid_pulse", 32'(jogada_pulso), 32'd1);
      chk("rst_mid_jogada_after", 32'(jogada), 32'h20);
      botoes = 7'b0; ticks(D + 6);
      $display("[TB] reset mid-operation");

      // Random segments: idle, single, multi or glitchy values held for random lengths
      for (int s = 0; s < 250; s++) begin
         kind = int'($urandom_range(0, 3));
         case (kind)
            0: pat = 7'b0;
            1: pat = 7'(1 << $urandom_range(0, 6));
            2: pat = 7'((1 << $urandom_range(0, 6)) | (1 << $urandom_range(0, 6)));
            default: pat = 7'($urandom_range(0, 127));
         endcase
         len = int'($urandom_range(1, 3 * D + 4));
         habilita = ($urandom_range(0, 4) != 0);
         reset = ($urandom_range(0, 40) == 0);
         botoes = pat;
         tick();
         reset = 1'b0;
         ticks(len - 1);
      end
      $display("[TB] random segments done");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
